// File: rtl/fetch_unit.sv
// Instruction fetch front end: credit-limited request issue, in-order tag FIFO,
// response-to-decode fetch queue, and redirect handling that drops stale responses.
module fetch_unit #(
    parameter int QDEPTH = 2,
    parameter int XLEN   = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_next,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    output logic            if_valid,
    output logic [XLEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc,
    input  logic            if_ready
);
    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = $clog2(QDEPTH + 1);
    localparam logic [CW:0]   CREDIT = (CW + 1)'(QDEPTH);
    localparam logic [PW-1:0] LAST   = PW'(QDEPTH - 1);

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + PW'(1);
    endfunction

    logic [XLEN-1:0] tag_mem_q [QDEPTH];
    logic [XLEN-1:0] tag_mem_d [QDEPTH];
    logic [XLEN-1:0] q_pc_q    [QDEPTH];
    logic [XLEN-1:0] q_pc_d    [QDEPTH];
    logic [XLEN-1:0] q_instr_q [QDEPTH];
    logic [XLEN-1:0] q_instr_d [QDEPTH];

    logic [PW-1:0] tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
    logic [PW-1:0] q_head_q, q_head_d, q_tail_q, q_tail_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] drop_q, drop_d;

    logic credit_ok, accept, rsp_fire, rsp_keep, pop;

    // Queue entries count against credit so every response is guaranteed a slot.
    assign credit_ok      = ({1'b0, outstanding_q} + {1'b0, count_q}) < CREDIT;
    assign imem_req_valid = !reset && !redirect_valid && credit_ok;
    assign imem_req_addr  = pc;
    assign accept         = imem_req_valid && imem_req_ready;
    assign rsp_fire       = imem_rsp_valid && !reset;
    assign rsp_keep       = rsp_fire && !redirect_valid && (drop_q == '0);

    assign if_valid = !reset && (count_q != '0);
    assign if_instr = q_instr_q[q_head_q];
    assign if_pc    = q_pc_q[q_head_q];
    assign pop      = if_valid && if_ready && !redirect_valid;

    always_comb begin
        pc_next = pc;
        if (reset)
            pc_next = '0;
        else if (redirect_valid)
            pc_next = {redirect_target[XLEN-1:2], 2'b00};
        else if (accept)
            pc_next = pc + XLEN'(4);
    end

    always_comb begin
        tag_mem_d     = tag_mem_q;
        q_pc_d        = q_pc_q;
        q_instr_d     = q_instr_q;
        tag_wr_d      = tag_wr_q;
        tag_rd_d      = tag_rd_q;
        q_head_d      = q_head_q;
        q_tail_d      = q_tail_q;
        drop_d        = drop_q;
        outstanding_d = outstanding_q + CW'(accept) - CW'(rsp_fire);
        count_d       = count_q + CW'(rsp_keep) - CW'(pop);

        if (accept) begin
            tag_mem_d[tag_wr_q] = pc;
            tag_wr_d            = wrap_inc(tag_wr_q);
        end
        if (rsp_fire)
            tag_rd_d = wrap_inc(tag_rd_q);
        if (rsp_keep) begin
            q_pc_d[q_tail_q]    = tag_mem_q[tag_rd_q];
            q_instr_d[q_tail_q] = imem_rsp_data;
            q_tail_d            = wrap_inc(q_tail_q);
        end
        if (pop)
            q_head_d = wrap_inc(q_head_q);

        // Redirect flushes decode-side state; still-outstanding requests become drops.
        if (redirect_valid) begin
            q_head_d = '0;
            q_tail_d = '0;
            count_d  = '0;
            drop_d   = outstanding_q - CW'(rsp_fire);
        end else if (rsp_fire && (drop_q != '0)) begin
            drop_d = drop_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tag_wr_q      <= '0;
            tag_rd_q      <= '0;
            q_head_q      <= '0;
            q_tail_q      <= '0;
            outstanding_q <= '0;
            count_q       <= '0;
            drop_q        <= '0;
        end else begin
            tag_wr_q      <= tag_wr_d;
            tag_rd_q      <= tag_rd_d;
            q_head_q      <= q_head_d;
            q_tail_q      <= q_tail_d;
            outstanding_q <= outstanding_d;
            count_q       <= count_d;
            drop_q        <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        tag_mem_q <= tag_mem_d;
        q_pc_q    <= q_pc_d;
        q_instr_q <= q_instr_d;
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based model of fetch/drop/deliver behaviour.
module tb_fetch_unit;
    localparam int QDEPTH = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_ready;

    fetch_unit #(.QDEPTH(QDEPTH), .XLEN(32)) dut (
        .clk(clk), .reset(reset), .pc(pc), .pc_next(pc_next),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .redirect_valid(redirect_valid),
        .redirect_target(redirect_target), .if_valid(if_valid),
        .if_instr(if_instr), .if_pc(if_pc), .if_ready(if_ready)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; bit stale; int acc; } flight_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } entry_t;

    flight_t     inflight[$];
    entry_t      ready_q[$];
    logic [31:0] model_pc;
    int          cyc;
    int          tests;
    int          fails;
    int          delivered;
    bit          rsp_now;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s cycle=%0d observed=0x%08h expected=0x%08h", tag, cyc, obs, exp);
        end
    endtask

    // Predicts outputs from the model, compares, then advances the model by one cycle.
    task automatic checkOutput(input logic rst_i, input logic redir_i, input logic [31:0] tgt_i,
                               input logic req_rdy_i, input logic if_rdy_i);
        logic        exp_valid;
        logic        exp_accept;
        logic [31:0] exp_pcn;
        flight_t     f;
        exp_valid  = !rst_i && !redir_i && ((inflight.size() + ready_q.size()) < QDEPTH);
        exp_accept = exp_valid && req_rdy_i;
        exp_pcn    = rst_i ? 32'h0 : redir_i ? {tgt_i[31:2], 2'b00}
                   : exp_accept ? model_pc + 32'd4 : model_pc;

        chk("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_valid});
        chk("pc_next", pc_next, exp_pcn);
        chk("if_valid", {31'b0, if_valid}, {31'b0, (!rst_i && ready_q.size() > 0)});
        if (exp_valid) chk("req_addr", imem_req_addr, model_pc);
        if (!rst_i && ready_q.size() > 0) begin
            chk("if_pc", if_pc, ready_q[0].pc);
            chk("if_instr", if_instr, ready_q[0].instr);
        end

        if (rst_i) begin
            inflight.delete();
            ready_q.delete();
        end else if (redir_i) begin
            ready_q.delete();
            if (rsp_now) void'(inflight.pop_front());
            foreach (inflight[i]) inflight[i].stale = 1'b1;
        end else begin
            if (if_rdy_i && ready_q.size() > 0) begin
                void'(ready_q.pop_front());
                delivered++;
            end
            if (rsp_now) begin
                f = inflight.pop_front();
                if (!f.stale) ready_q.push_back('{pc: f.addr, instr: mem_word(f.addr)});
            end
            if (exp_accept) inflight.push_back('{addr: model_pc, stale: 1'b0, acc: cyc});
        end
        model_pc = exp_pcn;
    endtask

    // Drives one cycle of inputs (responses only for requests accepted in an earlier cycle).
    task automatic applyStimulus(input logic rst_i, input logic redir_i, input logic [31:0] tgt_i,
                                 input logic req_rdy_i, input logic rsp_en_i, input logic if_rdy_i);
        rsp_now         = rsp_en_i && !rst_i && inflight.size() > 0 && inflight[0].acc < cyc;
        reset           = rst_i;
        redirect_valid  = redir_i;
        redirect_target = tgt_i;
        imem_req_ready  = req_rdy_i;
        if_ready        = if_rdy_i;
        pc              = model_pc;
        imem_rsp_valid  = rsp_now;
        imem_rsp_data   = rsp_now ? mem_word(inflight[0].addr) : $urandom;
        #2;
        checkOutput(rst_i, redir_i, tgt_i, req_rdy_i, if_rdy_i);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        tests = 0; fails = 0; cyc = 0; delivered = 0; model_pc = 32'h0; rsp_now = 1'b0;
        reset = 1'b1; pc = 32'h0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
        imem_rsp_data = 32'h0; redirect_valid = 1'b0; redirect_target = 32'h0; if_ready = 1'b0;
        @(posedge clk);
        #1;

        repeat (3) applyStimulus(1, 0, 32'h0, 1, 0, 0);

        // Streaming from address 0 with single-cycle memory latency.
        repeat (12) applyStimulus(0, 0, 32'h0, 1, 1, 1);

        // Decode stalled: credit fills, then issue stops until decode drains.
        repeat (2) applyStimulus(1, 0, 32'h0, 1, 0, 0);
        repeat (6) applyStimulus(0, 0, 32'h0, 1, 1, 0);
        repeat (8) applyStimulus(0, 0, 32'h0, 1, 1, 1);

        // Redirect with two requests in flight; their responses must be dropped.
        repeat (2) applyStimulus(1, 0, 32'h0, 1, 0, 0);
        repeat (2) applyStimulus(0, 0, 32'h0, 1, 0, 0);
        applyStimulus(0, 1, 32'h100, 1, 0, 1);
        repeat (8) applyStimulus(0, 0, 32'h0, 1, 1, 1);

        // Misaligned redirect target.
        applyStimulus(0, 1, 32'h203, 1, 0, 1);
        repeat (5) applyStimulus(0, 0, 32'h0, 1, 1, 1);

        // Redirect colliding with a response and a decode pop, then back-to-back redirects.
        repeat (2) applyStimulus(0, 0, 32'h0, 1, 1, 0);
        applyStimulus(0, 1, 32'h400, 1, 1, 1);
        applyStimulus(0, 1, 32'h500, 1, 1, 1);
        applyStimulus(0, 1, 32'h604, 1, 1, 1);
        repeat (8) applyStimulus(0, 0, 32'h0, 1, 1, 1);

        // Address wrap at the top of memory, then reset with two outstanding.
        repeat (2) applyStimulus(1, 0, 32'h0, 1, 0, 0);
        applyStimulus(0, 1, 32'hFFFF_FFF8, 1, 0, 0);
        repeat (2) applyStimulus(0, 0, 32'h0, 1, 0, 0);
        repeat (2) applyStimulus(1, 0, 32'h0, 1, 1, 1);
        repeat (6) applyStimulus(0, 0, 32'h0, 1, 1, 1);

        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) == 0), $urandom,
                          1'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
